color_scan_sequencer: RTL and testbench

COLOR_SCAN_SEQUENCER -- requirements
Module: color_scan_sequencer

---
 rtl/color_scan_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_color_scan_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/color_scan_sequencer.sv
// Sequences a colour sensor through red, green and blue filters, captures each
// frequency measurement, and reports the dominant colour after every scan.
module color_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [17:0] MIN_FREQ       = 18'd200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        meas_done,
  input  logic [17:0] frequency,
  output logic [1:0]  filter_sel,
  output logic        cs_enable,
  output logic        done_ack,
  output logic [17:0] red_freq,
  output logic [17:0] green_freq,
  output logic [17:0] blue_freq,
  output logic [1:0]  color_id,
  output logic        results_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned FREQ_W  = 18;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) > 21) ? $clog2(CNT_MAX + 1) : 21;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_ACK     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         channel;
  logic [CNT_W-1:0]   cnt;
  logic               settle_end;
  logic               timeout_hit;
  logic               last_channel;
  logic               cs_enable_d;
  logic               done_ack_d;
  logic               busy_d;
  logic               results_valid_d;
  logic [FREQ_W-1:0]  max_freq;
  logic [1:0]         dominant;
  logic [FREQ_W-1:0]  capture_val;

  // Sensor {S2,S3} code for each channel index.
  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      2'd0:    filter_code = 2'b00;
      2'd1:    filter_code = 2'b11;
      default: filter_code = 2'b01;
    endcase
  endfunction

  always_comb begin
    settle_end   = (cnt == SETTLE_LAST);
    timeout_hit  = (cnt == TIMEOUT_LAST);
    last_channel = (channel == 2'd2);
    capture_val  = meas_done ? frequency : '0;
  end

  // Largest channel wins; strict compares keep ties on the earlier colour.
  always_comb begin
    max_freq = red_freq;
    dominant = 2'd1;
    if (green_freq > max_freq) begin
      max_freq = green_freq;
      dominant = 2'd2;
    end
    if (blue_freq > max_freq) begin
      max_freq = blue_freq;
      dominant = 2'd3;
    end
    if (max_freq < MIN_FREQ) dominant = 2'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_SETTLE;
      S_SETTLE:  if (settle_end) state_next = S_MEASURE;
      S_MEASURE: if (meas_done || timeout_hit) state_next = S_ACK;
      S_ACK:     state_next = last_channel ? S_DONE : S_SETTLE;
      S_DONE:    state_next = continuous ? S_SETTLE : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so their flops line up with the state.
  always_comb begin
    cs_enable_d     = 1'b0;
    done_ack_d      = 1'b0;
    busy_d          = 1'b1;
    results_valid_d = 1'b0;
    case (state_next)
      S_IDLE:    busy_d = 1'b0;
      S_MEASURE: cs_enable_d = 1'b1;
      S_ACK: begin
        cs_enable_d = 1'b1;
        done_ack_d  = 1'b1;
      end
      S_DONE:    results_valid_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      channel       <= 2'd0;
      cnt           <= '0;
      filter_sel    <= 2'b00;
      cs_enable     <= 1'b0;
      done_ack      <= 1'b0;
      busy          <= 1'b0;
      results_valid <= 1'b0;
      timeout_err   <= 1'b0;
      red_freq      <= '0;
      green_freq    <= '0;
      blue_freq     <= '0;
      color_id      <= 2'd0;
    end else begin
      cs_enable     <= cs_enable_d;
      done_ack      <= done_ack_d;
      busy          <= busy_d;
      results_valid <= results_valid_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            channel     <= 2'd0;
            filter_sel  <= filter_code(2'd0);
            timeout_err <= 1'b0;
            cnt         <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_end) cnt <= '0;
          else            cnt <= cnt + CNT_W'(1);
        end
        S_MEASURE: begin
          // A measurement arriving on the last watchdog cycle still counts.
          if (meas_done || timeout_hit) begin
            case (channel)
              2'd0:    red_freq   <= capture_val;
              2'd1:    green_freq <= capture_val;
              default: blue_freq  <= capture_val;
            endcase
            if (!meas_done) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ACK: begin
          cnt <= '0;
          if (last_channel) begin
            color_id <= dominant;
          end else begin
            channel    <= channel + 2'd1;
            filter_sel <= filter_code(channel + 2'd1);
          end
        end
        S_DONE: begin
          if (continuous) begin
            channel    <= 2'd0;
            filter_sel <= filter_code(2'd0);
            cnt        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Directed bench for color_scan_sequencer with a behavioural frequency-counter model.
module tb_color_scan_sequencer;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        meas_done = 1'b0;
  logic [17:0] frequency = '0;
  logic [1:0]  filter_sel;
  logic        cs_enable;
  logic        done_ack;
  logic [17:0] red_freq;
  logic [17:0] green_freq;
  logic [17:0] blue_freq;
  logic [1:0]  color_id;
  logic        results_valid;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  int rv_base;

  color_scan_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MIN_FREQ      (18'd200)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .meas_done    (meas_done),
    .frequency    (frequency),
    .filter_sel   (filter_sel),
    .cs_enable    (cs_enable),
    .done_ack     (done_ack),
    .red_freq     (red_freq),
    .green_freq   (green_freq),
    .blue_freq    (blue_freq),
    .color_id     (color_id),
    .results_valid(results_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (results_valid === 1'b1) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [17:0] ch_freq(input int ch);
    case (ch)
      0:       ch_freq = red_freq;
      1:       ch_freq = green_freq;
      default: ch_freq = blue_freq;
    endcase
  endfunction

  function automatic logic [1:0] exp_filter(input int ch);
    case (ch)
      0:       exp_filter = 2'b00;
      1:       exp_filter = 2'b11;
      default: exp_filter = 2'b01;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_filter"}, filter_sel, 0);
    check({tag, "_cs"}, cs_enable, 0);
    check({tag, "_ack"}, done_ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, results_valid, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_red"}, red_freq, 0);
    check({tag, "_green"}, green_freq, 0);
    check({tag, "_blue"}, blue_freq, 0);
    check({tag, "_color"}, color_id, 0);
  endtask

  // Counter model for one channel: answer after a short delay, or stay silent.
  task automatic do_channel(input int ch, input logic [17:0] f, input bit skip);
    int n;
    n = 0;
    while (cs_enable !== 1'b1 && n < int'(SETTLE) + 10) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("cs_wait_ch%0d", ch), cs_enable, 1);
    check($sformatf("filter_ch%0d", ch), filter_sel, exp_filter(ch));
    check($sformatf("ack_low_ch%0d", ch), done_ack, 0);
    if (!skip) begin
      @(negedge clock);
      @(negedge clock);
      check($sformatf("ack_before_done_ch%0d", ch), done_ack, 0);
      meas_done = 1'b1;
      frequency = f;
      @(negedge clock);
      meas_done = 1'b0;
      frequency = '0;
      check($sformatf("capture_ch%0d", ch), ch_freq(ch), f);
      check($sformatf("ack_high_ch%0d", ch), done_ack, 1);
    end else begin
      n = 0;
      while (done_ack !== 1'b1 && n < int'(TIMEOUT) + 4) begin
        @(negedge clock);
        n++;
      end
      check($sformatf("timeout_ack_ch%0d", ch), done_ack, 1);
      check($sformatf("timeout_zero_ch%0d", ch), ch_freq(ch), 0);
      check($sformatf("timeout_err_ch%0d", ch), timeout_err, 1);
    end
    @(negedge clock);
    check($sformatf("ack_one_cycle_ch%0d", ch), done_ack, 0);
  endtask

  task automatic scan(input logic [17:0] f0, input logic [17:0] f1, input logic [17:0] f2,
                      input int skip, input logic [1:0] exp_id, input bit do_start,
                      input bit expect_idle, input bit drop_cont, input bit poke);
    if (do_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_filter", filter_sel, 0);
      check("start_cs", cs_enable, 0);
      check("start_terr_clear", timeout_err, 0);
    end
    do_channel(0, f0, skip == 0);
    if (poke) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    do_channel(1, f1, skip == 1);
    if (drop_cont) continuous = 1'b0;
    do_channel(2, f2, skip == 2);
    check("done_valid", results_valid, 1);
    check("done_color", color_id, exp_id);
    check("done_busy", busy, 1);
    @(negedge clock);
    check("valid_pulse", results_valid, 0);
    check("held_red", red_freq, (skip == 0) ? 18'd0 : f0);
    check("held_green", green_freq, (skip == 1) ? 18'd0 : f1);
    check("held_blue", blue_freq, (skip == 2) ? 18'd0 : f2);
    check("held_color", color_id, exp_id);
    if (expect_idle) begin
      check("idle_busy", busy, 0);
    end else begin
      check("restart_busy", busy, 1);
      check("restart_filter", filter_sel, 0);
      check("restart_cs", cs_enable, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_busy", busy, 0);

    scan(18'd1000, 18'd3000, 18'd2000, -1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("single_scan_pulses", rv_cnt, 1);
    scan(18'd100, 18'd150, 18'd120, -1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    scan(18'd500, 18'd500, 18'd400, -1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    scan(18'd700, 18'd555, 18'd900, 1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("terr_sticky", timeout_err, 1);

    // Threshold boundary (200 is not below MIN_FREQ) plus a start while busy.
    rv_base = rv_cnt;
    scan(18'd200, 18'd199, 18'd199, -1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    check("poke_idle", busy, 0);
    check("poke_pulses", rv_cnt, rv_base + 1);

    rv_base = rv_cnt;
    continuous = 1'b1;
    scan(18'd300, 18'd200, 18'd100, -1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    scan(18'd250, 18'd260, 18'd270, -1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clock);
    check("cont_idle", busy, 0);
    check("cont_pulses", rv_cnt, rv_base + 2);

    // Reset while green is being measured.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    do_channel(0, 18'd1234, 1'b0);
    n = 0;
    while (cs_enable !== 1'b1 && n < int'(SETTLE) + 10) begin
      @(negedge clock);
      n++;
    end
    check("mid_green_cs", cs_enable, 1);
    check("mid_green_filter", filter_sel, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("mid_reset");
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("mid_reset_stays_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
